// File: rtl/dispatch_stage_pkg.sv
// Shared definitions for the dispatch stage: machine widths, opcode
// constants, the dispatch packet layout and a branch-opcode helper.
package dispatch_stage_pkg;

  localparam int SYS_N_WAY    = 2;
  localparam int SYS_IB_DEPTH = 8;
  localparam int SYS_XLEN     = 32;

  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic                valid;
    logic [31:0]         inst;
    logic [SYS_XLEN-1:0] PC;
    logic [SYS_XLEN-1:0] NPC;
    logic [4:0]          src1;
    logic [4:0]          src2;
    logic [4:0]          dest;
  } DISPATCH_PACKET_R10K;

  // Conditional branches and both jump forms redirect control flow.
  function automatic logic isBranchOp(input logic [6:0] opcode);
    return (opcode == OP_BRANCH) || (opcode == OP_JAL) || (opcode == OP_JALR);
  endfunction

endpackage

// File: rtl/dispatch_stage_if.sv
// Fetch-side and dispatch-side signals of the dispatch stage.
// master = fetch/ROB/RS environment, slave = the dispatch stage itself.
interface dispatch_stage_if
  import dispatch_stage_pkg::*;
#(
  parameter int N_WAY    = SYS_N_WAY,
  parameter int IB_DEPTH = SYS_IB_DEPTH,
  parameter int XLEN     = SYS_XLEN
);
  localparam int CNT_W = $clog2(IB_DEPTH) + 1;

  logic [N_WAY-1:0]                if_valid;
  logic [N_WAY-1:0][31:0]          if_inst;
  logic [N_WAY-1:0][XLEN-1:0]      if_PC;
  logic [N_WAY-1:0][XLEN-1:0]      if_NPC;
  logic                            if_stall;
  logic [N_WAY-1:0]                dispatched;
  logic                            branch_haz;
  DISPATCH_PACKET_R10K [N_WAY-1:0] dispatch_packet;
  logic [N_WAY-1:0]                branch_inst;
  logic [CNT_W-1:0]                ib_count;

  modport master (
    output if_valid, if_inst, if_PC, if_NPC, dispatched, branch_haz,
    input  if_stall, dispatch_packet, branch_inst, ib_count
  );

  modport slave (
    input  if_valid, if_inst, if_PC, if_NPC, dispatched, branch_haz,
    output if_stall, dispatch_packet, branch_inst, ib_count
  );

endinterface

// File: rtl/dispatch_stage_decode.sv
// Per-way field extraction: register specifiers, destination suppression
// for stores/branches, and the branch-class flag.
module dispatch_decode
  import dispatch_stage_pkg::*;
(
  input  logic                valid_i,
  input  logic [31:0]         inst_i,
  input  logic [SYS_XLEN-1:0] pc_i,
  input  logic [SYS_XLEN-1:0] npc_i,
  output DISPATCH_PACKET_R10K packet_o,
  output logic                branch_o
);

  // Build the packet straight from the instruction word; stores and
  // conditional branches write no register, so their dest reads as x0.
  always_comb begin
    packet_o       = '0;
    packet_o.valid = valid_i;
    packet_o.inst  = inst_i;
    packet_o.PC    = pc_i;
    packet_o.NPC   = npc_i;
    packet_o.src1  = inst_i[19:15];
    packet_o.src2  = inst_i[24:20];
    packet_o.dest  = inst_i[11:7];
    if ((inst_i[6:0] == OP_STORE) || (inst_i[6:0] == OP_BRANCH)) begin
      packet_o.dest = 5'd0;
    end
    branch_o = valid_i && isBranchOp(inst_i[6:0]);
  end

endmodule

// File: rtl/dispatch_stage.sv
// Dispatch stage: circular instruction buffer between fetch and dispatch.
// Optional feature macro: DISPATCH_BYPASS_EN -- when the buffer is empty,
// the fetch group is presented on dispatch_packet in the same cycle and
// only the ways not accepted are written into the buffer.
module dispatch_stage
  import dispatch_stage_pkg::*;
#(
  parameter int N_WAY    = SYS_N_WAY,
  parameter int IB_DEPTH = SYS_IB_DEPTH,
  parameter int XLEN     = SYS_XLEN
)(
  input logic              clock,
  input logic              reset,
  dispatch_stage_if.slave  bus
);

  localparam int PTR_W = $clog2(IB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] NPC;
  } entry_t;

  entry_t              entries_q [IB_DEPTH];
  logic [IB_DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                bypassActive;
  logic                stall;
  logic [N_WAY-1:0]    showValid;
  entry_t [N_WAY-1:0]  showEntry;
  entry_t [N_WAY-1:0]  fetchEntry;
  entry_t [N_WAY-1:0]  pushEntry;
  logic [N_WAY-1:0]    acceptMask;
  logic [N_WAY-1:0]    writeEn;
  logic [CNT_W-1:0]    fetchCount, acceptCount, popCount, pushStart, pushCount;

  DISPATCH_PACKET_R10K [N_WAY-1:0] packets;
  logic [N_WAY-1:0]                branchFlags;

  // Free space is judged on the registered count only, so a same-cycle pop
  // never lets a group in that could otherwise overflow the buffer.
  assign stall = (CNT_W'(IB_DEPTH) - count_q) < CNT_W'(N_WAY);

  // Choose what each dispatch way shows: the oldest buffered entries in age
  // order, or the raw fetch group when the empty-buffer bypass applies.
  always_comb begin
    bypassActive = 1'b0;
`ifdef DISPATCH_BYPASS_EN
    bypassActive = (count_q == '0) && !bus.branch_haz && !reset;
`endif
    for (int i = 0; i < N_WAY; i++) begin
      fetchEntry[i] = '{inst: bus.if_inst[i], PC: bus.if_PC[i], NPC: bus.if_NPC[i]};
      showValid[i]  = (CNT_W'(i) < count_q) && valid_q[head_q + PTR_W'(i)];
      showEntry[i]  = entries_q[head_q + PTR_W'(i)];
      if (bypassActive) begin
        showValid[i] = bus.if_valid[i];
        showEntry[i] = fetchEntry[i];
      end
    end
  end

  // Work out how many entries leave and enter this cycle and where the
  // incoming ways land; a flush overrides everything and empties the buffer.
  always_comb begin
    acceptMask  = bus.dispatched & showValid;
    acceptCount = '0;
    fetchCount  = '0;
    for (int i = 0; i < N_WAY; i++) begin
      if (acceptMask[i] && (acceptCount == CNT_W'(i))) begin
        acceptCount = acceptCount + CNT_W'(1);
      end
      if (bus.if_valid[i] && (fetchCount == CNT_W'(i))) begin
        fetchCount = fetchCount + CNT_W'(1);
      end
    end

    popCount  = bypassActive ? '0 : acceptCount;
    pushStart = bypassActive ? acceptCount : '0;
    pushCount = stall ? '0 : (fetchCount - pushStart);

    for (int j = 0; j < N_WAY; j++) begin
      writeEn[j]   = !bus.branch_haz && (CNT_W'(j) < pushCount);
      pushEntry[j] = '0;
      for (int w = 0; w < N_WAY; w++) begin
        if (CNT_W'(w) == (pushStart + CNT_W'(j))) begin
          pushEntry[j] = fetchEntry[w];
        end
      end
    end

    head_d  = head_q + PTR_W'(popCount);
    tail_d  = tail_q + PTR_W'(pushCount);
    count_d = count_q + pushCount - popCount;
    valid_d = valid_q;
    for (int i = 0; i < N_WAY; i++) begin
      if (CNT_W'(i) < popCount) begin
        valid_d[head_q + PTR_W'(i)] = 1'b0;
      end
    end
    for (int j = 0; j < N_WAY; j++) begin
      if (writeEn[j]) begin
        valid_d[tail_q + PTR_W'(j)] = 1'b1;
      end
    end

    if (bus.branch_haz) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
    end
  end

  // Pointer, occupancy and entry-valid state; reset empties the buffer at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Instruction payload storage; contents only matter where valid_q is set.
  always_ff @(posedge clock) begin
    for (int j = 0; j < N_WAY; j++) begin
      if (writeEn[j]) begin
        entries_q[tail_q + PTR_W'(j)] <= pushEntry[j];
      end
    end
  end

  for (genvar g = 0; g < N_WAY; g++) begin : gen_decode
    dispatch_decode u_decode (
      .valid_i  (showValid[g]),
      .inst_i   (showEntry[g].inst),
      .pc_i     (showEntry[g].PC),
      .npc_i    (showEntry[g].NPC),
      .packet_o (packets[g]),
      .branch_o (branchFlags[g])
    );
  end

  assign bus.dispatch_packet = packets;
  assign bus.branch_inst     = branchFlags;
  assign bus.if_stall        = stall;
  assign bus.ib_count        = count_q;

endmodule

// File: tb/tb_dispatch_stage.sv
// Directed bench for dispatch_stage (2-way, 8-entry buffer, 32-bit PC).
module tb_dispatch_stage;
  import dispatch_stage_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  dispatch_stage_if #(.N_WAY(2), .IB_DEPTH(8), .XLEN(32)) bus ();

  dispatch_stage #(.N_WAY(2), .IB_DEPTH(8), .XLEN(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] mkInst(input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [4:0] rd, input logic [6:0] op);
    return {7'b0, rs2, rs1, 3'b000, rd, op};
  endfunction

  task automatic applyStimulus(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                               input logic [31:0] pc0, input logic [31:0] pc1,
                               input logic [1:0] disp, input logic haz);
    bus.if_valid   = v;
    bus.if_inst[0] = i0;
    bus.if_inst[1] = i1;
    bus.if_PC[0]   = pc0;
    bus.if_PC[1]   = pc1;
    bus.if_NPC[0]  = pc0 + 32'd4;
    bus.if_NPC[1]  = pc1 + 32'd4;
    bus.dispatched = disp;
    bus.branch_haz = haz;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] addI, rAdd, brI;

  initial begin
    checks = 0;
    errors = 0;
    addI = mkInst(5'd0, 5'd0, 5'd1, 7'b0010011);
    rAdd = mkInst(5'd2, 5'd1, 5'd3, 7'b0110011);
    brI  = mkInst(5'd5, 5'd4, 5'd6, OP_BRANCH);
    reset = 1'b1;
    applyStimulus(2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 1'b0);
    tick();
    tick();
    checkOutput("rst_count", bus.ib_count, 0);
    checkOutput("rst_stall", bus.if_stall, 0);
    checkOutput("rst_v0", bus.dispatch_packet[0].valid, 0);
    checkOutput("rst_v1", bus.dispatch_packet[1].valid, 0);
    checkOutput("rst_br", bus.branch_inst, 0);
    reset = 1'b0;

    // Push two, dispatch both one cycle later
    applyStimulus(2'b11, rAdd, brI, 32'h0, 32'h4, 2'b00, 1'b0);
    tick();
    applyStimulus(2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 2'b11, 1'b0);
    #1;
    checkOutput("p2_count", bus.ib_count, 2);
    checkOutput("p2_v0", bus.dispatch_packet[0].valid, 1);
    checkOutput("p2_v1", bus.dispatch_packet[1].valid, 1);
    checkOutput("p2_pc0", bus.dispatch_packet[0].PC, 32'h0);
    checkOutput("p2_pc1", bus.dispatch_packet[1].PC, 32'h4);
    checkOutput("p2_npc1", bus.dispatch_packet[1].NPC, 32'h8);
    checkOutput("p2_src1", bus.dispatch_packet[0].src1, 1);
    checkOutput("p2_src2", bus.dispatch_packet[0].src2, 2);
    checkOutput("p2_dest0", bus.dispatch_packet[0].dest, 3);
    checkOutput("p2_bsrc1", bus.dispatch_packet[1].src1, 4);
    checkOutput("p2_bsrc2", bus.dispatch_packet[1].src2, 5);
    checkOutput("p2_dest1", bus.dispatch_packet[1].dest, 0);
    checkOutput("p2_br", bus.branch_inst, 2'b10);
    tick();
    applyStimulus(2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 1'b0);
    #1;
    checkOutput("p2_empty", bus.ib_count, 0);
    checkOutput("p2_gone", bus.dispatch_packet[0].valid, 0);

    // Fill to full and check stall/drop behaviour
    applyStimulus(2'b11, addI, addI, 32'h100, 32'h104, 2'b00, 1'b0);
    tick();
    applyStimulus(2'b11, addI, addI, 32'h108, 32'h10C, 2'b00, 1'b0);
    #1;
    checkOutput("fill_c2", bus.ib_count, 2);
    tick();
    applyStimulus(2'b11, addI, addI, 32'h110, 32'h114, 2'b00, 1'b0);
    tick();
    applyStimulus(2'b11, addI, addI, 32'h118, 32'h11C, 2'b00, 1'b0);
    #1;
    checkOutput("fill_c6", bus.ib_count, 6);
    checkOutput("fill_st6", bus.if_stall, 0);
    tick();
    applyStimulus(2'b11, addI, addI, 32'h200, 32'h204, 2'b00, 1'b0);
    #1;
    checkOutput("fill_c8", bus.ib_count, 8);
    checkOutput("fill_st8", bus.if_stall, 1);
    tick();
    applyStimulus(2'b00, addI, addI, 32'h0, 32'h0, 2'b01, 1'b0);
    #1;
    checkOutput("full_hold", bus.ib_count, 8);
    checkOutput("full_pc0", bus.dispatch_packet[0].PC, 32'h100);
    tick();
    applyStimulus(2'b11, addI, addI, 32'h300, 32'h304, 2'b00, 1'b0);
    #1;
    checkOutput("fill_c7", bus.ib_count, 7);
    checkOutput("fill_st7", bus.if_stall, 1);
    tick();
    applyStimulus(2'b00, addI, addI, 32'h0, 32'h0, 2'b11, 1'b0);
    #1;
    checkOutput("drop7_count", bus.ib_count, 7);
    checkOutput("drop7_pc0", bus.dispatch_packet[0].PC, 32'h104);
    checkOutput("drop7_pc1", bus.dispatch_packet[1].PC, 32'h108);
    tick();
    applyStimulus(2'b00, addI, addI, 32'h0, 32'h0, 2'b11, 1'b0);
    #1;
    checkOutput("drain_c5", bus.ib_count, 5);
    tick();

    // Non-prefix dispatch mask pops nothing; prefix of one pops one
    applyStimulus(2'b00, addI, addI, 32'h0, 32'h0, 2'b10, 1'b0);
    #1;
    checkOutput("m10_c3", bus.ib_count, 3);
    checkOutput("m10_pc0", bus.dispatch_packet[0].PC, 32'h114);
    tick();
    applyStimulus(2'b00, addI, addI, 32'h0, 32'h0, 2'b01, 1'b0);
    #1;
    checkOutput("m10_hold", bus.ib_count, 3);
    tick();
    applyStimulus(2'b11, addI, addI, 32'h400, 32'h404, 2'b00, 1'b0);
    #1;
    checkOutput("m01_c2", bus.ib_count, 2);
    checkOutput("m01_pc0", bus.dispatch_packet[0].PC, 32'h118);
    checkOutput("m01_pc1", bus.dispatch_packet[1].PC, 32'h11C);
    tick();

    // Flush with five entries and a live fetch group
    applyStimulus(2'b01, addI, addI, 32'h408, 32'h0, 2'b00, 1'b0);
    #1;
    checkOutput("pre_c4", bus.ib_count, 4);
    tick();
    applyStimulus(2'b11, brI, brI, 32'h500, 32'h504, 2'b11, 1'b1);
    #1;
    checkOutput("pre_c5", bus.ib_count, 5);
    tick();
    applyStimulus(2'b00, addI, addI, 32'h0, 32'h0, 2'b00, 1'b0);
    #1;
    checkOutput("fl_count", bus.ib_count, 0);
    checkOutput("fl_v0", bus.dispatch_packet[0].valid, 0);
    checkOutput("fl_v1", bus.dispatch_packet[1].valid, 0);
    checkOutput("fl_br", bus.branch_inst, 0);
    checkOutput("fl_stall", bus.if_stall, 0);

    // Twenty back-to-back push/pop cycles wrapping the pointers
    for (int j = 0; j <= 20; j++) begin
      applyStimulus((j < 20) ? 2'b11 : 2'b00, addI, addI, 32'(8 * j), 32'(8 * j + 4),
                    (j > 0) ? 2'b11 : 2'b00, 1'b0);
      #1;
      if (j > 0) begin
        checkOutput("wrap_v0", bus.dispatch_packet[0].valid, 1);
        checkOutput("wrap_pc0", bus.dispatch_packet[0].PC, 64'(8 * (j - 1)));
        checkOutput("wrap_pc1", bus.dispatch_packet[1].PC, 64'(8 * (j - 1) + 4));
      end
      tick();
    end
    applyStimulus(2'b00, addI, addI, 32'h0, 32'h0, 2'b00, 1'b0);
    #1;
    checkOutput("wrap_end", bus.ib_count, 0);

    // Reset mid-operation, then the first push right after release
    applyStimulus(2'b11, addI, addI, 32'h700, 32'h704, 2'b00, 1'b0);
    tick();
    applyStimulus(2'b11, addI, addI, 32'h710, 32'h714, 2'b00, 1'b0);
    #1;
    checkOutput("mr_pre", bus.ib_count, 2);
    reset = 1'b1;
    #1;
    checkOutput("mr_count", bus.ib_count, 0);
    checkOutput("mr_v0", bus.dispatch_packet[0].valid, 0);
    checkOutput("mr_stall", bus.if_stall, 0);
    applyStimulus(2'b01, addI, addI, 32'h800, 32'h0, 2'b00, 1'b0);
    reset = 1'b0;
    tick();
    applyStimulus(2'b00, addI, addI, 32'h0, 32'h0, 2'b01, 1'b0);
    #1;
    checkOutput("mr_c1", bus.ib_count, 1);
    checkOutput("mr_pc0", bus.dispatch_packet[0].PC, 32'h800);
    tick();
    applyStimulus(2'b00, addI, addI, 32'h0, 32'h0, 2'b00, 1'b0);
    #1;
    checkOutput("mr_c0", bus.ib_count, 0);

`ifdef DISPATCH_BYPASS_EN
    // Empty buffer: way 0 goes straight out, way 1 is buffered
    applyStimulus(2'b11, addI, addI, 32'h600, 32'h604, 2'b01, 1'b0);
    #1;
    checkOutput("bp_v0", bus.dispatch_packet[0].valid, 1);
    checkOutput("bp_pc0", bus.dispatch_packet[0].PC, 32'h600);
    checkOutput("bp_v1", bus.dispatch_packet[1].valid, 1);
    tick();
    applyStimulus(2'b00, addI, addI, 32'h0, 32'h0, 2'b00, 1'b0);
    #1;
    checkOutput("bp_c1", bus.ib_count, 1);
    checkOutput("bp_pc_next", bus.dispatch_packet[0].PC, 32'h604);
`else
    // Without bypass, a fetch group shows up exactly one cycle later
    applyStimulus(2'b11, addI, addI, 32'h600, 32'h604, 2'b01, 1'b0);
    #1;
    checkOutput("lat_v0_now", bus.dispatch_packet[0].valid, 0);
    tick();
    applyStimulus(2'b00, addI, addI, 32'h0, 32'h0, 2'b00, 1'b0);
    #1;
    checkOutput("lat_v0_next", bus.dispatch_packet[0].valid, 1);
    checkOutput("lat_pc0", bus.dispatch_packet[0].PC, 32'h600);
    checkOutput("lat_c2", bus.ib_count, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
